// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell
// plus a borrow flop. A start/busy/done handshake lets a controlling FSM
// sequence operations; one result per WIDTH+2 cycles back-to-back.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag on ovf).
// Handshake: start is sampled only in IDLE; busy is high for exactly WIDTH
// cycles after the accepting edge; done then pulses for one cycle with
// diff/borrow/ovf valid and held until the next completion. start seen
// while busy or done is dropped, never queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Counter is at least one bit wide so WIDTH=1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_d;
  logic             bit_br;
  logic             last_step;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign bit_d     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign bit_br    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign last_step = (state_q == SHIFT) && (cnt_q == LAST);

  // Next-state and datapath: capture in IDLE, shift in SHIFT, publish on the last step.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        res_d              = res_q >> 1;
        res_d[WIDTH-1]     = bit_d;
        br_d               = bit_br;
        cnt_d              = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = res_d;
          borrow_d = bit_br;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  // Keep operand sign bits from capture; the result sign is the final cell output.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (last_step) begin
      ovf_d = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
    end
  end

  // Overflow registers, updated alongside diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
// pushed when an operation is launched and popped when done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic [1:0]   dbg_state;

  // Expected {diff, borrow, ovf}
  logic [W+1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    logic         brw;
    logic         ov;
    d   = x - y;
    brw = (x < y);
`ifdef SERIAL_SUB_OVF_EN
    ov  = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
`else
    ov  = 1'b0;
`endif
    return {d, brw, ov};
  endfunction

  // Scoreboard: compare on every done pulse, and busy/done exclusivity each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check_eq("diff",   {24'd0, diff},  {24'd0, e[W+1:2]});
          check_eq("borrow", {31'd0, borrow}, {31'd0, e[1]});
          check_eq("ovf",    {31'd0, ovf},    {31'd0, e[0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One full operation; with disturb, operands and start toggle while busy,
  // and start is held during the done cycle. Neither may affect the result.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_first", {31'd0, busy}, 32'd1);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      if (disturb) begin
        a = W'($urandom);
        b = W'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      check_eq("busy_hold", {31'd0, busy}, 32'd1);
      check_eq("done_low_busy", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start = disturb;
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("idle_after", {31'd0, busy}, 32'd0);
    check_eq("state_idle", {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check_eq("rst_busy",   {31'd0, busy},   32'd0);
    check_eq("rst_done",   {31'd0, done},   32'd0);
    check_eq("rst_diff",   {24'd0, diff},   32'd0);
    check_eq("rst_borrow", {31'd0, borrow}, 32'd0);
    check_eq("rst_ovf",    {31'd0, ovf},    32'd0);
    check_eq("rst_state",  {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    do_op(8'd200, 8'd55, 1'b0);
    do_op(8'd10,  8'd20, 1'b0);
    do_op(8'h80,  8'h01, 1'b0);
    do_op(8'h00,  8'h00, 1'b0);
    do_op(8'h00,  8'h01, 1'b0);
    do_op(8'h7F,  8'hFF, 1'b1);
    do_op(8'hFF,  8'hFF, 1'b1);

    // start held high: a new result every W+2 cycles
    @(negedge clk);
    a = 8'd150; b = 8'd3; start = 1'b1;
    exp_q.push_back(model(a, b));
    for (int op = 0; op < 3; op++) begin
      for (int k = 1; k <= W + 2; k++) begin
        @(negedge clk);
        if (k == W + 1) check_eq("b2b_done", {31'd0, done}, 32'd1);
        else            check_eq("b2b_nodone", {31'd0, done}, 32'd0);
        if (k == W + 2) begin
          if (op < 2) begin
            a = W'($urandom); b = W'($urandom);
            exp_q.push_back(model(a, b));
          end else begin
            start = 1'b0;
          end
        end
      end
    end
    repeat (W + 3) @(negedge clk);

    // Random operations
    for (int n = 0; n < 20; n++) begin
      do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), n[0]);
    end

    // Reset in the middle of SHIFT
    @(negedge clk);
    a = 8'd77; b = 8'd33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",   {31'd0, busy},   32'd0);
    check_eq("mid_rst_done",   {31'd0, done},   32'd0);
    check_eq("mid_rst_diff",   {24'd0, diff},   32'd0);
    check_eq("mid_rst_borrow", {31'd0, borrow}, 32'd0);
    check_eq("mid_rst_ovf",    {31'd0, ovf},    32'd0);
    check_eq("mid_rst_state",  {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check_eq("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    do_op(8'd77, 8'd33, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
